// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake plus operand and result buses of the serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = serial_sub_pkg::DEF_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
  );

endinterface

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell and a registered borrow.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave sub
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   ONE  = CW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aSh_q, aSh_d;
  logic [WIDTH-1:0] bSh_q, bSh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bor_q, bor_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cellD;
  logic             cellBout;

  full_subtractor_cell cell_u (
    .a_i    (aSh_q[0]),
    .b_i    (bSh_q[0]),
    .bin_i  (bor_q),
    .d_o    (cellD),
    .bout_o (cellBout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      aSh_q    <= '0;
      bSh_q    <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bor_q    <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      aSh_q    <= aSh_d;
      bSh_q    <= bSh_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bor_q    <= bor_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // busy/done are computed as next-state values so the outputs come straight from flops.
  always_comb begin
    state_d  = state_q;
    aSh_d    = aSh_q;
    bSh_d    = bSh_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bor_d    = bor_q;
    borrow_d = borrow_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (sub.start) begin
          state_d  = RUN;
          aSh_d    = sub.a;
          bSh_d    = sub.b;
          res_d    = '0;
          cnt_d    = '0;
          bor_d    = 1'b0;
          borrow_d = 1'b0;
          busy_d   = 1'b1;
        end
      end

      RUN: begin
        aSh_d = aSh_q >> 1;
        bSh_d = bSh_q >> 1;
        res_d = {cellD, res_q[WIDTH-1:1]};
        bor_d = cellBout;
        if (cnt_q == LAST) begin
          // Counter holds on the last bit so it never wraps for power-of-two widths.
          state_d  = DONE;
          borrow_d = cellBout;
          done_d   = 1'b1;
        end else begin
          cnt_d  = cnt_q + ONE;
          busy_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sub.busy   = busy_q;
  assign sub.done   = done_q;
  assign sub.diff   = res_q;
  assign sub.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8 using immediate assertions.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cycleNum;

  serial_subtractor_if #(.WIDTH(W)) sif ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sub   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycleNum = 0;
  always @(posedge clk) cycleNum <= cycleNum + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents operands with start for one edge, then scrambles the operand bus.
  task automatic applyStimulus(input logic [W-1:0] aVal, input logic [W-1:0] bVal);
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = aVal;
    sif.b     = bVal;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    sif.a     = 8'h5A;
    sif.b     = 8'hC3;
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] aVal, input logic [W-1:0] bVal,
                       input logic [W-1:0] expDiff, input logic expBorrow);
    int doneAt;
    int busyCycles;
    doneAt     = 0;
    busyCycles = 0;
    applyStimulus(aVal, bVal);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (sif.done) begin
        doneAt = c;
        break;
      end
      if (sif.busy) busyCycles++;
    end
    // First negedge after the accept edge is c=1, so done after edge k+8 appears at c=9.
    checkOutput({tag, " done latency"}, doneAt, 9);
    checkOutput({tag, " busy cycles"}, busyCycles, W);
    checkOutput({tag, " busy with done"}, sif.busy, 1'b0);
    checkOutput({tag, " diff"}, sif.diff, expDiff);
    checkOutput({tag, " borrow"}, sif.borrow, expBorrow);
    @(negedge clk);
    checkOutput({tag, " done one cycle"}, sif.done, 1'b0);
    checkOutput({tag, " diff held"}, sif.diff, expDiff);
    checkOutput({tag, " borrow held"}, sif.borrow, expBorrow);
  endtask

  initial begin
    int          doneAt;
    int          doneCount;
    logic        timedOut;
    logic [W-1:0] expA;
    logic [W-1:0] expB;
    int          lastDone;

    checks    = 0;
    errors    = 0;
    sif.start = 1'b0;
    sif.a     = '0;
    sif.b     = '0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", sif.busy, 1'b0);
    checkOutput("reset done", sif.done, 1'b0);
    checkOutput("reset diff", sif.diff, 8'h00);
    checkOutput("reset borrow", sif.borrow, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    runOp("35-12", 8'h35, 8'h12, 8'h23, 1'b0);
    runOp("00-01", 8'h00, 8'h01, 8'hFF, 1'b1);
    runOp("AA-AA", 8'hAA, 8'hAA, 8'h00, 1'b0);
    runOp("FF-00", 8'hFF, 8'h00, 8'hFF, 1'b0);
    runOp("01-FF", 8'h01, 8'hFF, 8'h02, 1'b1);

    // start held high through RUN and DONE with different operands
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = 8'h10;
    sif.b     = 8'h01;
    @(posedge clk);
    #1;
    sif.a = 8'h77;
    sif.b = 8'h11;
    doneAt    = 0;
    doneCount = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (sif.done) begin
        doneAt = c;
        doneCount++;
        break;
      end
    end
    checkOutput("hold first latency", doneAt, 9);
    checkOutput("hold first diff", sif.diff, 8'h0F);
    @(negedge clk);
    checkOutput("hold no requeue busy", sif.busy, 1'b0);
    checkOutput("hold done pulse end", sif.done, 1'b0);
    checkOutput("hold diff stable", sif.diff, 8'h0F);
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    @(negedge clk);
    checkOutput("hold second accepted", sif.busy, 1'b1);
    doneAt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (sif.done) begin
        doneAt = c;
        doneCount++;
        break;
      end
    end
    checkOutput("hold second latency", doneAt, 8);
    checkOutput("hold second diff", sif.diff, 8'h66);
    checkOutput("hold second borrow", sif.borrow, 1'b0);
    checkOutput("hold done count", doneCount, 2);
    repeat (2) @(negedge clk);

    // asynchronous reset in the middle of an operation
    applyStimulus(8'h80, 8'h01);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset busy", sif.busy, 1'b0);
    checkOutput("midreset done", sif.done, 1'b0);
    checkOutput("midreset diff", sif.diff, 8'h00);
    checkOutput("midreset borrow", sif.borrow, 1'b0);
    @(negedge clk);
    rst_n     = 1'b1;
    doneCount = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (sif.done || sif.busy) doneCount++;
    end
    checkOutput("after reset quiet", doneCount, 0);

    // random sweep with start held continuously
    $display("[TB] random sweep");
    lastDone  = 0;
    @(negedge clk);
    sif.a     = W'($urandom);
    sif.b     = W'($urandom);
    sif.start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      expA     = sif.a;
      expB     = sif.b;
      timedOut = 1'b1;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (sif.busy) begin
          timedOut = 1'b0;
          break;
        end
      end
      checkOutput("sweep accept timeout", timedOut, 1'b0);
      sif.a    = W'($urandom);
      sif.b    = W'($urandom);
      timedOut = 1'b1;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (sif.done) begin
          timedOut = 1'b0;
          break;
        end
      end
      checkOutput("sweep done timeout", timedOut, 1'b0);
      checkOutput("sweep diff", sif.diff, W'(expA - expB));
      checkOutput("sweep borrow", sif.borrow, expA < expB);
      if (i > 0) checkOutput("sweep done spacing", (cycleNum - lastDone) >= 10, 1'b1);
      lastDone = cycleNum;
      if (timedOut) break;
    end
    sif.start = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
